// File: rtl/rv_fetch_unit_pkg.sv
// Shared definitions for the uRV fetch stage: reset vector default, instruction
// width, the {ir,pc} word carried between memory response, skid and output,
// and the word-alignment helper used on redirect targets.
package rv_fetch_unit_pkg;

  localparam int          RV_INSN_WIDTH   = 32;
  localparam logic [31:0] RV_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [RV_INSN_WIDTH-1:0] ir;
    logic [31:0]              pc;
  } fetch_word_t;

  // Redirect targets are forced onto a word boundary; misalignment is not trapped here.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv_fetch_skid.sv
// One-entry skid buffer holding a fetched {ir,pc} that arrived while decode stalled.
// Latency: push visible on valid/data the cycle after; pop clears the cycle after.
// Backpressure: none internally; the caller never pushes while full (fetch stops issuing).
// Ports: clk/rst (async active-high), push/pop/flush controls, din in, dout/valid out.
module rv_fetch_skid
  import rv_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        valid
);

  fetch_word_t data_q;
  logic        valid_q;

  // Flush wins over push so a kill arriving with a landing response discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (push) begin
      valid_q <= 1'b1;
      data_q  <= din;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/rv_fetch_unit.sv
// uRV instruction fetch: PC generation, 1-cycle synchronous imem requests, output to decode.
// Latency: request 1 cycle after reset release, valid 2 cycles after request; redirect target valid 2 cycles after x_bra_i.
// Backpressure: f_stall_i holds outputs; a request is only issued when its word has a landing slot (output or skid).
// Ports: clk_i/rst_i; f_stall_i, f_kill_i, x_bra_i/x_pc_bra_i from the pipeline;
//        im_addr_o/im_rd_o/im_data_i to instruction memory; f_ir_o/f_pc_o/f_valid_o to decode.
module rv_fetch_unit
  import rv_fetch_unit_pkg::*;
#(
  parameter logic [31:0] g_reset_vector = RV_RESET_VECTOR
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     f_stall_i,
  input  logic                     f_kill_i,
  input  logic                     x_bra_i,
  input  logic [31:0]              x_pc_bra_i,
  output logic [31:0]              im_addr_o,
  output logic                     im_rd_o,
  input  logic [RV_INSN_WIDTH-1:0] im_data_i,
  output logic [RV_INSN_WIDTH-1:0] f_ir_o,
  output logic [31:0]              f_pc_o,
  output logic                     f_valid_o
);

  logic        running;
  logic        resp_pending;
  logic [31:0] pc;
  logic [31:0] resp_pc;

  fetch_word_t out_q;
  logic        out_valid;
  fetch_word_t resp_word;
  fetch_word_t skid_word;
  logic        skid_valid;
  logic        skid_push;
  logic        skid_pop;
  logic        flush;

  assign flush     = x_bra_i | f_kill_i;
  assign resp_word = '{ir: im_data_i, pc: resp_pc};

  // Request side. A stalled, valid output with a word already in flight means that word
  // will need the skid; holding off the next request keeps every issued word landable.
  assign im_addr_o = x_bra_i ? align_word(x_pc_bra_i) : pc;
  assign im_rd_o   = x_bra_i |
                     (running & ~skid_valid & ~(f_stall_i & out_valid & resp_pending));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      running      <= 1'b0;
      pc           <= g_reset_vector;
      resp_pending <= 1'b0;
      resp_pc      <= '0;
    end else begin
      running      <= 1'b1;
      resp_pending <= im_rd_o;
      if (im_rd_o) begin
        pc      <= im_addr_o + 32'd4;
        resp_pc <= im_addr_o;
      end
    end
  end

  // Response landing. A response cannot arrive while the skid drains, because no request
  // is issued while the skid is occupied.
  assign skid_push = ~flush & f_stall_i & resp_pending & out_valid;
  assign skid_pop  = ~flush & ~f_stall_i & skid_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!f_stall_i) begin
      if (skid_valid) begin
        out_q     <= skid_word;
        out_valid <= 1'b1;
      end else if (resp_pending) begin
        out_q     <= resp_word;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (resp_pending && !out_valid) begin
      // Stalled but the output slot is empty: fill it directly instead of the skid.
      out_q     <= resp_word;
      out_valid <= 1'b1;
    end
  end

  rv_fetch_skid u_skid (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (skid_push),
    .pop   (skid_pop),
    .flush (flush),
    .din   (resp_word),
    .dout  (skid_word),
    .valid (skid_valid)
  );

  assign f_ir_o    = out_q.ir;
  assign f_pc_o    = out_q.pc;
  assign f_valid_o = out_valid;

endmodule
